led_frame_sched: RTL
====================

# led_frame_sched

Frame scheduler for the LED control path. It decides when a new LED frame is built, snapshots the per-channel MeanR/MeanG/MeanB values, and writes one 12-bit word per channel into the LED FIFO with FIFO-full backpressure. It then kicks the serializer with `send_start` and tracks it until the frame has been shifted out. It sits between the frame-trigger sources (external `start` and an internal refresh timer) and the FIFO/serializer pair, all in the `clk_fast` domain.

## Interface
- `CH_NUM`, 8: number of LED channels (words per frame), 2..16
- `CW`, 4: colour component width; FIFO word is 3*CW = 12 bits
- `REFRESH_CYC`, 1000: auto-refresh period in `clk_fast` cycles, ≥ 2*CH_NUM+8
- `ACK_TMO`, 64: maximum cycles to wait for the serializer to assert `send_busy`

Ports:
- `clk_fast`  in  1  sole clock
- `rstn`  in  1  asynchronous, active-low reset
- `en`  in  1  level enable; frames are only started while high
- `auto_en`  in  1  enables the internal refresh timer
- `start`  in  1  single-cycle frame request
- `MeanR`, `MeanG`, `MeanB`  in  CW x [CH_NUM-1:0]  per-channel colour values
- `fifo_full`  in  1  FIFO full; no write is allowed while high
- `send_busy`  in  1  serializer busy, high while a frame is being shifted out
- `we`  out  1  FIFO write strobe
- `fifo_data_in`  out  3*CW  FIFO word {R,G,B}
- `send_start`  out  1  one-cycle serializer kick
- `busy`  out  1  high whenever state ≠ IDLE
- `start_drop`  out  1  one-cycle pulse when a trigger is discarded
- `ack_err`  out  1  one-cycle pulse on serializer acknowledge timeout
- `frame_cnt`  out  16  count of completed frames

## Operation
- **Trigger.** `trig = start | tick`. `tick` is a one-cycle pulse when the refresh timer equals REFRESH_CYC-1.
- **Refresh timer.** Counts 0..REFRESH_CYC-1 and wraps. It is held at 0 while `en` or `auto_en` is low.
- **Pending flag.** One level deep.
  - `trig` in IDLE with `en` high: the frame starts.
  - `trig` while busy with pending clear: pending is set.
  - `trig` while busy with pending already set: `start_drop` pulses.
  - `trig` in IDLE with `en` low is ignored.
  - `en` low clears pending.
- **State machine:**
  - IDLE: on (`trig` or pending) with `en` high, capture all MeanR/G/B into snapshot registers, set idx=0, clear pending, go to LOAD.
  - LOAD: `we = !fifo_full`. `fifo_data_in = {snapR[idx], snapG[idx], snapB[idx]}`, channel 0 first. Each write increments idx. After the write with idx=CH_NUM-1, go to KICK.
  - KICK: `send_start=1` for one cycle, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if `send_busy` is high, go to WAIT_DONE. Otherwise, after ACK_TMO cycles, pulse `ack_err` and return to IDLE; `frame_cnt` is not incremented.
  - WAIT_DONE: when `send_busy` goes low, increment `frame_cnt` (wraps 0xFFFF→0) and return to IDLE.
- **Snapshot.** Input changes after capture do not affect the frame in flight.
- **`en` dropped mid-frame.** The current frame completes; no partial frames reach the FIFO.
- **Reset.** Asynchronous reset at any point returns to IDLE. Words already written are not recalled; FIFO flush is the owner's responsibility.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, timer 0, pending 0, `frame_cnt` 0.
- `we`, `fifo_data_in`, `send_start` and `busy` decode combinationally from registered state; there is no combinational path from `fifo_full` except into `we`.
- With `trig` sampled at edge T and `fifo_full` low:
  - `we` is high in cycles T+1..T+CH_NUM.
  - `send_start` is high in cycle T+CH_NUM+1.
  - WAIT_ACK is entered at T+CH_NUM+2.
- Each cycle with `fifo_full` high during LOAD adds one cycle of latency; idx holds.
- `trig` and the WAIT_DONE→IDLE transition in the same cycle: pending is set, and the next frame starts from IDLE one cycle later.
- `tick` and `start` together count as one trigger.

## Test plan
- **Basic frame.** Reset; `en=1`, `auto_en=0`; MeanR=MeanG=MeanB={8,7,...,1} (channel 7 … channel 0); pulse `start`. Required: 8 consecutive writes 0x111, 0x222, …, 0x888; `send_start` one cycle after the last write; model `send_busy` high for 20 cycles → `frame_cnt`=1.
- **Backpressure.** Hold `fifo_full` high for cycles 3–6 of LOAD. Required: `we` low in those cycles, no word skipped or duplicated, frame latency +4.
- **Overrun.** Three `start` pulses while busy. Required: the 2nd sets pending and the frame restarts after IDLE; the 3rd produces one `start_drop` pulse; `frame_cnt`=2 at the end.
- **Auto refresh.** `auto_en=1`, REFRESH_CYC=1000, no `start`. Required: frames begin every 1000 cycles; timer stays at 0 while `en`=0.
- **Ack timeout.** `send_busy` held low. Required: `ack_err` pulses 64 cycles after `send_start`; return to IDLE; `frame_cnt` unchanged.
- **Reset/enable mid-LOAD.** `rstn` low at the 4th write: all outputs 0 immediately and idx=0. Separately, drop `en` at the 4th write: all 8 words still written and the frame completes.

Source files
------------

// File: rtl/led_frame_sched.sv
// LED frame scheduler: snapshots the per-channel colour means, streams one {R,G,B}
// word per channel into the LED FIFO, then kicks the serializer and tracks it to completion.

module led_frame_sched #(
    parameter int CH_NUM      = 8,
    parameter int CW          = 4,
    parameter int REFRESH_CYC = 1000,
    parameter int ACK_TMO     = 64
) (
    input  logic                      clk_fast,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      auto_en,
    input  logic                      start,
    input  logic [CH_NUM-1:0][CW-1:0] MeanR,
    input  logic [CH_NUM-1:0][CW-1:0] MeanG,
    input  logic [CH_NUM-1:0][CW-1:0] MeanB,
    input  logic                      fifo_full,
    input  logic                      send_busy,
    output logic                      we,
    output logic [3*CW-1:0]           fifo_data_in,
    output logic                      send_start,
    output logic                      busy,
    output logic                      start_drop,
    output logic                      ack_err,
    output logic [15:0]               frame_cnt
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int TMR_W = $clog2(REFRESH_CYC);
    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [IDX_W-1:0]          idx_r;
    logic [TMO_W-1:0]          tmo_r;
    logic [TMR_W-1:0]          timer_r;
    logic                      pending_r;
    logic                      start_drop_r;
    logic [15:0]               frame_cnt_r;
    logic [CH_NUM-1:0][CW-1:0] snap_r_r;
    logic [CH_NUM-1:0][CW-1:0] snap_g_r;
    logic [CH_NUM-1:0][CW-1:0] snap_b_r;

    logic tick_s;
    logic trig_s;
    logic go_s;
    logic wr_s;
    logic last_wr_s;
    logic tmo_hit_s;
    logic done_s;

    // Trigger and transfer qualifiers shared by the FSM and the datapath registers
    always_comb begin
        tick_s    = (timer_r == TMR_LAST);
        trig_s    = start | tick_s;
        go_s      = (state_r == ST_IDLE) && en && (trig_s || pending_r);
        wr_s      = (state_r == ST_LOAD) && !fifo_full;
        last_wr_s = wr_s && (idx_r == IDX_LAST);
        tmo_hit_s = (state_r == ST_WAIT_ACK) && !send_busy && (tmo_r == TMO_LAST);
        done_s    = (state_r == ST_WAIT_DONE) && !send_busy;
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) state_s = ST_LOAD;
                else      state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (last_wr_s) state_s = ST_KICK;
                else           state_s = ST_LOAD;
            end
            ST_KICK: state_s = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (send_busy)      state_s = ST_WAIT_DONE;
                else if (tmo_hit_s) state_s = ST_IDLE;
                else                state_s = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (!send_busy) state_s = ST_IDLE;
                else            state_s = ST_WAIT_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from registered state; only we sees fifo_full
    always_comb begin
        we           = wr_s;
        send_start   = (state_r == ST_KICK);
        busy         = (state_r != ST_IDLE);
        ack_err      = tmo_hit_s;
        start_drop   = start_drop_r;
        frame_cnt    = frame_cnt_r;
        if (state_r == ST_LOAD) begin
            fifo_data_in = {snap_r_r[idx_r], snap_g_r[idx_r], snap_b_r[idx_r]};
        end else begin
            fifo_data_in = {(3*CW){1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Channel index: restarts per frame, advances only on accepted writes
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn)          idx_r <= {IDX_W{1'b0}};
        else if (go_s)      idx_r <= {IDX_W{1'b0}};
        else if (last_wr_s) idx_r <= {IDX_W{1'b0}};
        else if (wr_s)      idx_r <= idx_r + IDX_W'(1);
        else                idx_r <= idx_r;
    end

    // Serializer acknowledge timeout counter
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn)                                       tmo_r <= {TMO_W{1'b0}};
        else if (state_r == ST_KICK)                     tmo_r <= {TMO_W{1'b0}};
        else if ((state_r == ST_WAIT_ACK) && !send_busy) tmo_r <= tmo_r + TMO_W'(1);
        else                                             tmo_r <= tmo_r;
    end

    // Refresh timer, parked at zero unless both enables are high
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn)                timer_r <= {TMR_W{1'b0}};
        else if (!en || !auto_en) timer_r <= {TMR_W{1'b0}};
        else if (tick_s)          timer_r <= {TMR_W{1'b0}};
        else                      timer_r <= timer_r + TMR_W'(1);
    end

    // One-deep pending trigger; a trigger that finds it already full is reported
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            pending_r    <= 1'b0;
            start_drop_r <= 1'b0;
        end else begin
            start_drop_r <= trig_s && (state_r != ST_IDLE) && pending_r;
            if (!en)                                  pending_r <= 1'b0;
            else if (go_s)                            pending_r <= 1'b0;
            else if (trig_s && (state_r != ST_IDLE))  pending_r <= 1'b1;
            else                                      pending_r <= pending_r;
        end
    end

    // Colour snapshot taken once per frame so later input changes cannot tear it
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            snap_r_r <= {(CH_NUM*CW){1'b0}};
            snap_g_r <= {(CH_NUM*CW){1'b0}};
            snap_b_r <= {(CH_NUM*CW){1'b0}};
        end else if (go_s) begin
            snap_r_r <= MeanR;
            snap_g_r <= MeanG;
            snap_b_r <= MeanB;
        end else begin
            snap_r_r <= snap_r_r;
            snap_g_r <= snap_g_r;
            snap_b_r <= snap_b_r;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn)       frame_cnt_r <= 16'd0;
        else if (done_s) frame_cnt_r <= frame_cnt_r + 16'd1;
        else             frame_cnt_r <= frame_cnt_r;
    end

endmodule
